// File: rtl/opb_register_simulink2ppc_latched.sv
// Fabric-to-PowerPC OPB register: latches a user word on user_valid and exposes it,
// together with sticky NEW/OVF flags, as a two-word read window on the OPB.
module opb_register_simulink2ppc_latched #(
   parameter logic [31:0] C_BASEADDR   = 32'h01014700,
   parameter logic [31:0] C_HIGHADDR   = 32'h010147FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   input  logic [31:0]             user_data_in,
   input  logic                    user_valid,
   output logic                    user_new
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_HOLD} state_t;

   state_t                    state_q, state_d;
   logic                      rnw_q, rnw_d;
   logic                      word_q, word_d;
   logic [31:0]               data_q, data_d;
   logic                      new_q, new_d;
   logic                      ovf_q, ovf_d;
   logic [0:C_OPB_DWIDTH-1]   sl_dbus_q, sl_dbus_d;

   logic hit;
   logic start;
   logic in_ack;
   logic data_rd_clr;
   logic ovf_wr_clr;

   assign hit         = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign start       = (state_q == ST_IDLE) && OPB_select && hit;
   assign in_ack      = (state_q == ST_ACK);
   assign data_rd_clr = in_ack && rnw_q && !word_q;
   assign ovf_wr_clr  = in_ack && !rnw_q && word_q && OPB_DBus[C_OPB_DWIDTH-2];

   always_comb begin
      state_d = state_q;
      rnw_d   = rnw_q;
      word_d  = word_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACK;
               rnw_d   = OPB_RNW;
               word_d  = OPB_ABus[C_OPB_AWIDTH-3];
            end
         end
         ST_ACK:  state_d = ST_HOLD;
         ST_HOLD: if (!OPB_select) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A capture in the same cycle as a clear always wins; OVF only sets when the
   // previous word was never consumed.
   always_comb begin
      data_d = user_valid ? user_data_in : data_q;
      new_d  = new_q;
      ovf_d  = ovf_q;
      if (data_rd_clr) new_d = 1'b0;
      if (ovf_wr_clr)  ovf_d = 1'b0;
      if (user_valid) begin
         new_d = 1'b1;
         if (new_q && !data_rd_clr) ovf_d = 1'b1;
      end
   end

   // Read data is registered from the next-state values so that a word captured
   // on the edge entering ACK is the one returned.
   always_comb begin
      sl_dbus_d = '0;
      if (start && OPB_RNW) begin
         if (OPB_ABus[C_OPB_AWIDTH-3]) begin
            sl_dbus_d[C_OPB_DWIDTH-1] = new_d;
            sl_dbus_d[C_OPB_DWIDTH-2] = ovf_d;
         end else begin
            sl_dbus_d = data_d;
         end
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q   <= ST_IDLE;
         rnw_q     <= 1'b0;
         word_q    <= 1'b0;
         data_q    <= '0;
         new_q     <= 1'b0;
         ovf_q     <= 1'b0;
         sl_dbus_q <= '0;
      end else begin
         state_q   <= state_d;
         rnw_q     <= rnw_d;
         word_q    <= word_d;
         data_q    <= data_d;
         new_q     <= new_d;
         ovf_q     <= ovf_d;
         sl_dbus_q <= sl_dbus_d;
      end
   end

   assign Sl_DBus    = sl_dbus_q;
   assign Sl_xferAck = in_ack;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign user_new   = new_q;

   localparam bit unused_family = |C_FAMILY;
   logic unused_inputs;
   assign unused_inputs = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-3],
                            OPB_DBus[C_OPB_DWIDTH-1]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
// Randomized bench for the fabric-to-PPC latched register, checked against a
// transaction-level model of the DATA word and NEW/OVF flags.
module tb_opb_register_simulink2ppc_latched;

   localparam logic [31:0] A_DATA = 32'h01014700;
   localparam logic [31:0] A_STAT = 32'h01014704;
   localparam logic [31:0] A_MISS = 32'h01014800;

   logic        OPB_Clk = 1'b0;
   logic        OPB_Rst_n;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
   logic [31:0] user_data_in;
   logic        user_valid;
   logic        user_new;

   int tests = 0;
   int fails = 0;

   // Reference model: the register seen as a word plus two sticky flags.
   logic [31:0] m_data;
   bit          m_new, m_ovf;

   always #5 OPB_Clk = ~OPB_Clk;

   opb_register_simulink2ppc_latched dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
      .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
      .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
      .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
      .user_data_in(user_data_in), .user_valid(user_valid), .user_new(user_new)
   );

   task automatic model_reset();
      m_data = '0; m_new = 0; m_ovf = 0;
   endtask

   task automatic model_capture(input logic [31:0] w);
      if (m_new) m_ovf = 1;
      m_new  = 1;
      m_data = w;
   endtask

   // Called and returns at posedge+1; select held for 'hold' cycles.
   task automatic opb_xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wdata,
                           input bit uv_ack, input logic [31:0] uv_word, input int hold,
                           output logic [31:0] rdata, output int acks, output int leaks);
      logic [31:0] tmp;
      OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = rnw ? 32'h0 : wdata; OPB_select = 1;
      acks = 0; rdata = '0; leaks = 0;
      for (int c = 0; c < hold; c++) begin
         @(negedge OPB_Clk);
         tmp = Sl_DBus;
         if (Sl_xferAck === 1'b1) begin
            acks++;
            rdata = tmp;
            if (uv_ack) begin user_valid = 1; user_data_in = uv_word; end
         end else if (tmp !== 32'h0) leaks++;
         @(posedge OPB_Clk); #1;
         user_valid = 0;
      end
      OPB_select = 0; OPB_RNW = 0; OPB_DBus = '0;
      @(negedge OPB_Clk);
      if (Sl_xferAck !== 1'b0) acks++;
      @(posedge OPB_Clk); #1;
   endtask

   task automatic pulse_valid(input logic [31:0] w);
      user_valid = 1; user_data_in = w;
      @(posedge OPB_Clk); #1;
      user_valid = 0;
      model_capture(w);
   endtask

   task automatic test_reset();
      logic [31:0] r; int a, l;
      OPB_Rst_n = 0; OPB_ABus = '0; OPB_BE = 4'hF; OPB_DBus = '0; OPB_RNW = 0;
      OPB_select = 0; OPB_seqAddr = 0; user_data_in = '0; user_valid = 0;
      model_reset();
      repeat (3) @(negedge OPB_Clk);
      tests++;
      if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0 || user_new !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: ack=%b dbus=%h new=%b, want 0/0/0", Sl_xferAck, Sl_DBus, user_new);
      end
      OPB_Rst_n = 1;
      @(posedge OPB_Clk); #1;
      opb_xfer(A_DATA, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (a != 1 || r !== 32'h0 || l != 0) begin
         fails++;
         $display("FAIL reset_data_read: acks=%0d data=%h leaks=%0d, want 1/0/0", a, r, l);
      end
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (a != 1 || r !== 32'h0) begin
         fails++;
         $display("FAIL reset_status_read: acks=%0d data=%h, want 1/0", a, r);
      end
      $display("[TB] reset: data/status read after reset done");
   endtask

   task automatic test_capture();
      logic [31:0] r; int a, l;
      pulse_valid(32'hDEADBEEF);
      tests++;
      if (user_new !== 1'b1) begin
         fails++; $display("FAIL capture_user_new: got %b want 1", user_new);
      end
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (a != 1 || r !== {30'b0, m_ovf, m_new} || r !== 32'h1) begin
         fails++; $display("FAIL capture_status: acks=%0d got %h want 00000001", a, r);
      end
      opb_xfer(A_DATA, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (a != 1 || r !== m_data) begin
         fails++; $display("FAIL capture_data: acks=%0d got %h want %h", a, r, m_data);
      end
      m_new = 0;
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (r !== 32'h0 || user_new !== 1'b0) begin
         fails++; $display("FAIL capture_cleared: status=%h user_new=%b want 0/0", r, user_new);
      end
      $display("[TB] capture: DEADBEEF captured and read back");
   endtask

   task automatic test_overflow();
      logic [31:0] r; int a, l;
      pulse_valid(32'h1);
      pulse_valid(32'h2);
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (r !== 32'h3) begin
         fails++; $display("FAIL ovf_status: got %h want 00000003", r);
      end
      opb_xfer(A_STAT, 0, 32'h2, 0, 0, 3, r, a, l);
      m_ovf = 0;
      tests++;
      if (a != 1 || r !== 32'h0) begin
         fails++; $display("FAIL ovf_clear_write: acks=%0d dbus=%h want 1/0", a, r);
      end
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (r !== 32'h1) begin
         fails++; $display("FAIL ovf_after_clear: got %h want 00000001", r);
      end
      opb_xfer(A_DATA, 1, 0, 0, 0, 3, r, a, l);
      m_new = 0;
      tests++;
      if (r !== 32'h2) begin
         fails++; $display("FAIL ovf_data: got %h want 00000002", r);
      end
      $display("[TB] overflow: two captures set OVF, write cleared it");
   endtask

   task automatic test_set_wins();
      logic [31:0] r, exp; int a, l;
      pulse_valid(32'h44);
      exp = m_data;
      opb_xfer(A_DATA, 1, 0, 1, 32'h55, 3, r, a, l);
      m_new = 0; model_capture(32'h55);
      tests++;
      if (r !== exp || r !== 32'h44) begin
         fails++; $display("FAIL setwin_read: got %h want %h", r, exp);
      end
      tests++;
      if (user_new !== 1'b1) begin
         fails++; $display("FAIL setwin_new: got %b want 1", user_new);
      end
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (r !== 32'h1) begin
         fails++; $display("FAIL setwin_status: got %h want 00000001", r);
      end
      opb_xfer(A_DATA, 1, 0, 0, 0, 3, r, a, l);
      m_new = 0;
      tests++;
      if (r !== 32'h55) begin
         fails++; $display("FAIL setwin_next: got %h want 00000055", r);
      end
      $display("[TB] set_wins: capture during DATA ack kept NEW");
   endtask

   task automatic test_miss_and_hold();
      logic [31:0] r; int a, l;
      opb_xfer(A_MISS, 1, 0, 0, 0, 4, r, a, l);
      tests++;
      if (a != 0 || l != 0) begin
         fails++; $display("FAIL miss: acks=%0d leaks=%0d want 0/0", a, l);
      end
      opb_xfer(A_STAT, 1, 0, 0, 0, 4, r, a, l);
      tests++;
      if (a != 1 || l != 0) begin
         fails++; $display("FAIL hold_one_ack: acks=%0d leaks=%0d want 1/0", a, l);
      end
      $display("[TB] miss_and_hold: miss ignored, long select acked once");
   endtask

   task automatic test_reset_mid_ack();
      logic [31:0] r; int a, l; bit seen;
      pulse_valid(32'hA);
      pulse_valid(32'hB);
      OPB_ABus = A_STAT; OPB_RNW = 1; OPB_select = 1;
      seen = 0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(negedge OPB_Clk);
         if (Sl_xferAck === 1'b1) seen = 1;
      end
      tests++;
      if (!seen) begin
         fails++; $display("FAIL rst_ack_timeout: no ack within 4 cycles, want ack");
      end
      #2 OPB_Rst_n = 0;
      #1;
      tests++;
      if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0 || user_new !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_ack: ack=%b dbus=%h new=%b want 0/0/0", Sl_xferAck, Sl_DBus, user_new);
      end
      OPB_select = 0; OPB_RNW = 0;
      @(negedge OPB_Clk);
      OPB_Rst_n = 1;
      model_reset();
      @(posedge OPB_Clk); #1;
      opb_xfer(A_STAT, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (a != 1 || r !== 32'h0) begin
         fails++; $display("FAIL rst_after_status: acks=%0d got %h want 1/0", a, r);
      end
      opb_xfer(A_DATA, 1, 0, 0, 0, 3, r, a, l);
      tests++;
      if (a != 1 || r !== 32'h0) begin
         fails++; $display("FAIL rst_after_data: acks=%0d got %h want 1/0", a, r);
      end
      $display("[TB] reset_mid_ack: ack dropped, flags cleared, next read ok");
   endtask

   task automatic test_random();
      logic [31:0] r, w, uw, exp; int a, l, op; bit uv;
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 4));
         w  = $urandom;
         uw = $urandom;
         uv = ($urandom_range(0, 3) == 0);
         exp = 32'h0;
         case (op)
            0: pulse_valid(w);
            1: begin
               exp = m_data;
               opb_xfer(A_DATA, 1, 0, uv, uw, 3, r, a, l);
               m_new = 0;
            end
            2: begin
               exp = {30'b0, m_ovf, m_new};
               opb_xfer(A_STAT, 1, 0, uv, uw, 3, r, a, l);
            end
            3: begin
               opb_xfer(A_STAT, 0, w, uv, uw, 3, r, a, l);
               if (w[1]) m_ovf = 0;
            end
            default: opb_xfer(A_DATA, 0, w, uv, uw, 3, r, a, l);
         endcase
         if (op != 0 && uv) model_capture(uw);
         if (op != 0) begin
            tests++;
            if (a != 1 || l != 0 || r !== exp) begin
               fails++;
               $display("FAIL rand_xfer[%0d] op=%0d: acks=%0d leaks=%0d data=%h want 1/0/%h",
                        i, op, a, l, r, exp);
            end
         end
         tests++;
         if (user_new !== m_new) begin
            fails++; $display("FAIL rand_new[%0d]: got %b want %b", i, user_new, m_new);
         end
         $display("[TB] rand %0d op=%0d uv=%0d new=%0d ovf=%0d", i, op, uv, m_new, m_ovf);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_capture();
      test_overflow();
      test_set_wins();
      test_miss_and_hold();
      test_reset_mid_ack();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
